if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC, computes PC+4, and presents the PC to instruction ROM.
- Latches the fetched instruction into the IF/ID pipeline register consumed by decode and by the load-use hazard unit's Instruction_ID input.
- Obeys the hazard unit's PCWrite/DWrite stall controls, plus branch/jump redirect and flush from the resolving stage; keeps saturating stall/flush performance counters.

---
 rtl/if_id_fetch_stage_pkg.sv | 17 +
 rtl/if_id_fetch_stage_if.sv | 33 +++
 rtl/if_id_fetch_stage_pipe_reg.sv | 38 +++
 rtl/if_id_fetch_stage.sv | 93 +++++++++
 tb/tb_if_id_fetch_stage.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/if_id_fetch_stage_pkg.sv
// rtl/if_id_fetch_stage_pkg.sv - shared pipeline constants and IF/ID bundle layout
package if_id_fetch_stage_pkg;

  localparam int               PIPE_DATA_WIDTH = 32;
  localparam logic [31:0]      PIPE_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0]      PIPE_NOP_INSTR  = 32'h0000_0000;
  localparam int               PIPE_CNT_WIDTH  = 16;
  localparam int               PC_INCREMENT    = 4;

  // IF/ID bundle as it sits in the pipeline register, MSB first
  typedef struct packed {
    logic [PIPE_DATA_WIDTH-1:0] pc4;
    logic [PIPE_DATA_WIDTH-1:0] instr;
    logic                       valid;
  } ifid_t;

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// rtl/if_id_fetch_stage_if.sv - fetch stage control, ROM and IF/ID signal bundle
interface if_id_fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic                  PCWrite_i;
  logic                  DWrite_i;
  logic                  Redirect_i;
  logic [DATA_WIDTH-1:0] RedirectPC_i;
  logic [DATA_WIDTH-1:0] Instruction_i;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [DATA_WIDTH-1:0] IFID_PC4_o;
  logic [DATA_WIDTH-1:0] IFID_Instruction_o;
  logic                  IFID_Valid_o;
  logic [CNT_WIDTH-1:0]  StallCount_o;
  logic [CNT_WIDTH-1:0]  FlushCount_o;

  // fetch stage side
  modport master (
    input  PCWrite_i, DWrite_i, Redirect_i, RedirectPC_i, Instruction_i,
    output PC_o, IFID_PC4_o, IFID_Instruction_o, IFID_Valid_o,
           StallCount_o, FlushCount_o
  );

  // hazard unit / ROM / decode side
  modport slave (
    output PCWrite_i, DWrite_i, Redirect_i, RedirectPC_i, Instruction_i,
    input  PC_o, IFID_PC4_o, IFID_Instruction_o, IFID_Valid_o,
           StallCount_o, FlushCount_o
  );

endinterface

// File: rtl/if_id_fetch_stage_pipe_reg.sv
// rtl/if_id_fetch_stage_pipe_reg.sv - pipeline register with async reset, sync clear and enable
module if_id_fetch_stage_pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // clear (flush) beats enable; clear reloads the reset value
  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = RESET_VAL;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  // storage with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - MIPS instruction fetch stage with IF/ID register and perf counters
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = PIPE_RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = PIPE_NOP_INSTR,
  parameter int                    CNT_WIDTH  = PIPE_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  if_id_fetch_stage_if.master bus
);

  localparam int                   IFID_W     = 2 * DATA_WIDTH + 1;
  localparam logic [IFID_W-1:0]    IFID_RESET = {{DATA_WIDTH{1'b0}}, NOP_INSTR, 1'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] pc_cur;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_load;
  logic                  pc_en;
  logic [IFID_W-1:0]     ifid_load;
  logic [IFID_W-1:0]     ifid_cur;
  logic [CNT_WIDTH-1:0]  stall_cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;
  logic [CNT_WIDTH-1:0]  flush_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q;

  // next-PC select: the older redirect outranks a younger load-use stall
  always_comb begin
    pc_plus4  = pc_cur + DATA_WIDTH'(PC_INCREMENT);
    pc_en     = bus.Redirect_i | bus.PCWrite_i;
    pc_load   = bus.Redirect_i ? {bus.RedirectPC_i[DATA_WIDTH-1:2], 2'b00} : pc_plus4;
    ifid_load = {pc_plus4, bus.Instruction_i, 1'b1};
  end

  if_id_fetch_stage_pipe_reg #(
    .WIDTH     (DATA_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (reset),
    .clear_i (1'b0),
    .en_i    (pc_en),
    .d_i     (pc_load),
    .q_o     (pc_cur)
  );

  // a redirect flushes IF/ID to a bubble even while decode is stalled
  if_id_fetch_stage_pipe_reg #(
    .WIDTH     (IFID_W),
    .RESET_VAL (IFID_RESET)
  ) u_ifid_reg (
    .clk     (clk),
    .rst     (reset),
    .clear_i (bus.Redirect_i),
    .en_i    (bus.DWrite_i),
    .d_i     (ifid_load),
    .q_o     (ifid_cur)
  );

  // saturating stall/flush counters; a redirected cycle is not a stall
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.PCWrite_i && !bus.Redirect_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (bus.Redirect_i && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  // counter storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PC_o               = pc_cur;
  assign bus.IFID_PC4_o         = ifid_cur[IFID_W-1 -: DATA_WIDTH];
  assign bus.IFID_Instruction_o = ifid_cur[DATA_WIDTH:1];
  assign bus.IFID_Valid_o       = ifid_cur[0];
  assign bus.StallCount_o       = stall_cnt_q;
  assign bus.FlushCount_o       = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - self-checking bench for if_id_fetch_stage
module tb_if_id_fetch_stage;

  typedef struct {
    logic        pcw;
    logic        dw;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        v;
    logic [3:0]  st;
    logic [3:0]  fl;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t vecs [12];
  vec_t sb_q [$];
  vec_t e;

  if_id_fetch_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) bus ();

  if_id_fetch_stage #(.CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return a ^ 32'hABCD_0000;
  endfunction

  always_comb bus.Instruction_i = rom(bus.PC_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pcw, input logic dw, input logic rd, input logic [31:0] rpc);
    bus.PCWrite_i    = pcw;
    bus.DWrite_i     = dw;
    bus.Redirect_i   = rd;
    bus.RedirectPC_i = rpc;
  endtask

  task automatic check_all(input string tag, input vec_t x);
    check({tag, ".pc"},    bus.PC_o, x.pc);
    check({tag, ".pc4"},   bus.IFID_PC4_o, x.pc4);
    check({tag, ".instr"}, bus.IFID_Instruction_o, x.instr);
    check({tag, ".valid"}, {31'd0, bus.IFID_Valid_o}, {31'd0, x.v});
    check({tag, ".stall"}, {28'd0, bus.StallCount_o}, {28'd0, x.st});
    check({tag, ".flush"}, {28'd0, bus.FlushCount_o}, {28'd0, x.fl});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //          pcw   dw    rd    rpc            pc             pc4            instr          v     st    fl
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0040_0004, 32'h0040_0004, 32'h2008_0005, 1'b1, 4'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0040_0008, 32'h0040_0008, 32'hAB8D_0004, 1'b1, 4'd0, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0040_0008, 32'h0040_0008, 32'hAB8D_0004, 1'b1, 4'd1, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0040_000C, 32'h0040_000C, 32'hAB8D_0008, 1'b1, 4'd1, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0040, 32'h0040_0040, 32'h0,        32'h0,         1'b0, 4'd1, 4'd1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0040_0044, 32'h0040_0044, 32'hAB8D_0040, 1'b1, 4'd1, 4'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0040_0044, 32'h0040_0048, 32'hAB8D_0044, 1'b1, 4'd2, 4'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h0040_0043, 32'h0040_0040, 32'h0,        32'h0,         1'b0, 4'd2, 4'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0040_0044, 32'h0,         32'h0,         1'b0, 4'd2, 4'd2};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b0, 4'd2, 4'd3};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0000, 32'h0000_0000, 32'h5432_FFFC, 1'b1, 4'd2, 4'd3};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0004, 32'hABCD_0000, 1'b1, 4'd2, 4'd3};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    e = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0};
    check_all("reset", e);
    reset = 1'b0;

    // table: drive at negedge, expectation queued, compared after the edge
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].pcw, vecs[i].dw, vecs[i].rd, vecs[i].rpc);
      sb_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_all($sformatf("vec%0d", i), e);
      @(negedge clk);
    end

    // redirect raised mid-cycle must not reach PC_o before the edge
    drive(1'b0, 1'b0, 1'b1, 32'h1234_5678);
    #1;
    check("nocomb.pc", bus.PC_o, 32'h0000_0004);
    @(posedge clk);
    #1;
    check("redir.pc", bus.PC_o, 32'h1234_5678);
    check("redir.valid", {31'd0, bus.IFID_Valid_o}, 32'd0);
    check("redir.flush", {28'd0, bus.FlushCount_o}, 32'd4);
    @(negedge clk);

    // stall counter counts up to all-ones then sticks
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (12) @(negedge clk);
    check("stall12", {28'd0, bus.StallCount_o}, 32'd14);
    repeat (8) @(negedge clk);
    check("stall_sat", {28'd0, bus.StallCount_o}, 32'd15);
    check("stall_hold.pc", bus.PC_o, 32'h1234_5678);
    check("stall_hold.flush", {28'd0, bus.FlushCount_o}, 32'd4);

    // flush counter saturates and redirect cycles do not count as stalls
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    repeat (11) @(negedge clk);
    check("flush_sat", {28'd0, bus.FlushCount_o}, 32'd15);
    @(negedge clk);
    check("flush_nowrap", {28'd0, bus.FlushCount_o}, 32'd15);
    check("flush.stall", {28'd0, bus.StallCount_o}, 32'd15);
    check("flush.pc", bus.PC_o, 32'h0000_0100);

    // one real fetch so IF/ID is valid, then async reset during a stall
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("pre_rst.valid", {31'd0, bus.IFID_Valid_o}, 32'd1);
    check("pre_rst.pc", bus.PC_o, 32'h0000_0104);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    e = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0};
    check_all("async_rst", e);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    e = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0040_0004, 32'h0040_0004, 32'h2008_0005, 1'b1, 4'd0, 4'd0};
    check_all("post_rst", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
